// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit for a MIPS-style EX stage.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each runs
// for 32 iterations, one per clock. Divide by zero is short-circuited to a
// zero result. Results are presented as {HI,LO} while in DONE.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, DIVZERO, CALC, DONE} state_t;

   state_t      state_reg, state_next;
   logic [5:0]  cnt_reg;
   logic [1:0]  op_reg;
   logic        sign_a_reg, sign_b_reg;
   logic [31:0] mag_a_reg, mag_b_reg;
   logic [64:0] acc_reg;
   logic [63:0] result_reg;

   logic        in_signed, in_sign_a, in_sign_b;
   logic [31:0] in_mag_a, in_mag_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [64:0] div_shift, div_next, acc_step;
   logic [32:0] div_trial;
   logic [31:0] quot, rem;
   logic [63:0] prod;
   logic [63:0] result_fix;
   logic        stall;

   // Operand magnitudes and signs as they will be latched (signed ops only)
   always_comb begin
      in_signed = ~op_i[0];
      in_sign_a = in_signed & opa_i[31];
      in_sign_b = in_signed & opb_i[31];
      in_mag_a  = in_sign_a ? (~opa_i + 32'd1) : opa_i;
      in_mag_b  = in_sign_b ? (~opb_i + 32'd1) : opb_i;
   end

   // One iteration step: shift-add multiply or restoring divide
   always_comb begin
      mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, mag_a_reg} : 33'd0);
      mul_next  = {mul_sum, acc_reg[31:1]};
      div_shift = {acc_reg[63:0], 1'b0};
      div_trial = div_shift[64:32] - {1'b0, mag_b_reg};
      div_next  = div_trial[32] ? div_shift : {div_trial, div_shift[31:1], 1'b1};
      acc_step  = op_reg[1] ? div_next : {1'b0, mul_next};
   end

   // Sign correction applied to the final iteration's value on entry to DONE
   always_comb begin
      quot = acc_step[31:0];
      rem  = acc_step[63:32];
      prod = acc_step[63:0];
      if (op_reg[1]) begin
         result_fix = {(sign_a_reg ? (~rem + 32'd1) : rem),
                       ((sign_a_reg ^ sign_b_reg) ? (~quot + 32'd1) : quot)};
      end else begin
         result_fix = (sign_a_reg ^ sign_b_reg) ? (~prod + 64'd1) : prod;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state and stall request; annul forces IDLE from any state
   always_comb begin
      state_next = state_reg;
      stall      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i && !annul_i) begin
               stall      = 1'b1;
               state_next = (op_i[1] && (opb_i == 32'd0)) ? DIVZERO : CALC;
            end
         end
         DIVZERO: begin
            stall      = 1'b1;
            state_next = DONE;
         end
         CALC: begin
            stall = 1'b1;
            if (cnt_reg == 6'd31) state_next = DONE;
         end
         DONE: begin
            if (!start_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (annul_i) state_next = IDLE;
   end

   // Operand latch, iteration datapath and result register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg    <= 6'd0;
         op_reg     <= 2'd0;
         sign_a_reg <= 1'b0;
         sign_b_reg <= 1'b0;
         mag_a_reg  <= 32'd0;
         mag_b_reg  <= 32'd0;
         acc_reg    <= 65'd0;
         result_reg <= 64'd0;
      end else if (annul_i) begin
         cnt_reg    <= 6'd0;
         result_reg <= 64'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  cnt_reg    <= 6'd0;
                  op_reg     <= op_i;
                  sign_a_reg <= in_sign_a;
                  sign_b_reg <= in_sign_b;
                  mag_a_reg  <= in_mag_a;
                  mag_b_reg  <= in_mag_b;
                  // Multiplier or dividend starts in the low word
                  acc_reg    <= {33'd0, (op_i[1] ? in_mag_a : in_mag_b)};
               end
            end
            CALC: begin
               acc_reg <= acc_step;
               cnt_reg <= cnt_reg + 6'd1;
               if (cnt_reg == 6'd31) result_reg <= result_fix;
            end
            DIVZERO: result_reg <= 64'd0;
            default: ;
         endcase
      end
   end

   // Outputs are only meaningful in DONE
   always_comb begin
      ready_o    = (state_reg == DONE);
      result_o   = ready_o ? result_reg : 64'd0;
      busy_o     = (state_reg != IDLE);
      stallreq_o = stall;
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: an arithmetic reference model plus a
// cycle-level view of when the unit is busy/ready, compared every cycle,
// with directed cases that pin known results and latencies.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start_i, annul_i;
   logic [1:0]  op_i;
   logic [31:0] opa_i, opb_i;
   logic [63:0] result_o;
   logic        ready_o, stallreq_o, busy_o;

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   muldiv_seq dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .opa_i      (opa_i),
      .opb_i      (opb_i),
      .annul_i    (annul_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .stallreq_o (stallreq_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   // Expected {HI,LO} from plain 64-bit arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      p = 64'd0;
      case (op)
         2'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
         end
         2'd1: p = {32'd0, a} * {32'd0, b};
         default: begin
            if (b != 32'd0) begin
               if (op == 2'd2) begin
                  sa = longint'($signed(a));
                  sb = longint'($signed(b));
               end else begin
                  sa = longint'({32'd0, a});
                  sb = longint'({32'd0, b});
               end
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-level model: an operation is outstanding from acceptance until
   // DONE is left; it needs 32 edges (1 for divide by zero) to finish.
   logic        m_active = 1'b0;
   int          m_left   = 0;
   logic [63:0] m_result = 64'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_active <= 1'b0;
         m_left   <= 0;
      end else if (annul_i) begin
         m_active <= 1'b0;
      end else if (!m_active) begin
         if (start_i) begin
            m_active <= 1'b1;
            m_left   <= (op_i[1] && opb_i == 32'd0) ? 1 : 32;
            m_result <= ref_result(op_i, opa_i, opb_i);
         end
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
      end else if (!start_i) begin
         m_active <= 1'b0;
      end
   end

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic e_ready, e_stall;
      if (check_en) begin
         e_ready = m_active && (m_left == 0);
         e_stall = (!m_active && start_i && !annul_i) || (m_active && m_left > 0);
         chk("ready_o", 64'(ready_o), 64'(e_ready));
         chk("busy_o", 64'(busy_o), 64'(m_active));
         chk("stallreq_o", 64'(stallreq_o), 64'(e_stall));
         chk("result_o", result_o, e_ready ? m_result : 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issue one operation, wait for ready_o (bounded), hold, then release
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit scramble,
                         output int lat, output int stalls, output logic [63:0] got);
      bit found = 1'b0;
      start_i = 1'b1;
      op_i    = op;
      opa_i   = a;
      opb_i   = b;
      lat     = -1;
      stalls  = 0;
      got     = 64'd0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (stallreq_o) stalls++;
         if (ready_o) begin
            found = 1'b1;
            lat   = k;
            got   = result_o;
            break;
         end
         if (scramble && k >= 1) begin
            #1;
            op_i  = 2'($urandom_range(0, 3));
            opa_i = $urandom;
            opb_i = $urandom;
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: no ready_o within 40 cycles, op=%0d a=%h b=%h", op, a, b);
      end
      repeat (hold + 1) tick();
      start_i = 1'b0;
      tick();
   endtask

   task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
      int lat, stalls;
      logic [63:0] got;
      run_op(op, a, b, 1, 1'b1, lat, stalls, got);
      chk({name, "_result"}, got, exp);
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_stalls"}, 64'(stalls), 64'(exp_lat));
      $display("op %s: op=%0d a=%h b=%h result=%h latency=%0d", name, op, a, b, got, lat);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, stalls;
      logic [63:0] got;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      op_i = 2'd0; opa_i = 32'd0; opb_i = 32'd0;

      // Pin the reference model with hand-computed results
      chk("model_divu", ref_result(2'd3, 32'd100, 32'd7), 64'h00000002_0000000E);
      chk("model_div", ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
      chk("model_mult", ref_result(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
      chk("model_ovf", ref_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);

      tick();
      check_en = 1'b1;
      @(negedge clk);
      chk("reset_result", result_o, 64'd0);
      chk("reset_flags", {61'd0, ready_o, stallreq_o, busy_o}, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_reset_busy", 64'(busy_o), 64'd0);

      directed("divu_100_7", 2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      directed("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
      directed("mult_m3_5", 2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 33);
      directed("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 33);
      directed("div_by_zero", 2'd2, 32'd5, 32'd0, 64'd0, 2);
      directed("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);

      // Annul at CALC cycle 10, then a fresh DIVU 9/3
      start_i = 1'b1; op_i = 2'd3; opa_i = 32'd1000; opb_i = 32'd7;
      repeat (11) tick();
      annul_i = 1'b1; start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      @(negedge clk);
      chk("annul_busy", 64'(busy_o), 64'd0);
      chk("annul_ready", 64'(ready_o), 64'd0);
      $display("op annul: busy=%0d ready=%0d after annul", busy_o, ready_o);
      tick();
      directed("divu_9_3", 2'd3, 32'd9, 32'd3, 64'h00000000_00000003, 33);

      // Reset at CALC cycle 20
      start_i = 1'b1; op_i = 2'd0; opa_i = 32'h1234_5678; opb_i = 32'h9ABC_DEF0;
      repeat (21) tick();
      rst = 1'b1; start_i = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_mid_result", result_o, 64'd0);
      chk("rst_mid_flags", {61'd0, ready_o, stallreq_o, busy_o}, 64'd0);
      $display("op reset: busy=%0d ready=%0d stall=%0d result=%h", busy_o, ready_o, stallreq_o, result_o);
      tick();
      rst = 1'b0;
      tick();

      // Randomized operations, occasionally annulled part way through
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
         if ($urandom_range(0, 9) == 0) begin
            start_i = 1'b1; op_i = rop; opa_i = ra; opb_i = rb;
            repeat ($urandom_range(1, 30)) tick();
            annul_i = 1'b1; start_i = 1'b0;
            tick();
            annul_i = 1'b0;
            tick();
            $display("op rand%0d: op=%0d a=%h b=%h annulled", n, rop, ra, rb);
         end else begin
            run_op(rop, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat, stalls, got);
            $display("op rand%0d: op=%0d a=%h b=%h result=%h latency=%0d", n, rop, ra, rb, got, lat);
         end
      end

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL provide `clk  in  1`: the rising-edge clock for all state.
REQ-002 The block SHALL provide `rst  in  1`: reset, synchronous, active-high.
REQ-003 The block SHALL provide `start_i  in  1`: EX requests an operation; held high until ready_o is observed.
REQ-004 The block SHALL provide `op_i  in  2`: operation select; 00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
REQ-005 The block SHALL provide `opa_i  in  32`: multiplicand or dividend.
REQ-006 The block SHALL provide `opb_i  in  32`: multiplier or divisor.
REQ-007 The block SHALL provide `annul_i  in  1`: abort the current operation (branch flush or exception).
REQ-008 The block SHALL provide `result_o  out  64`: {HI,LO}; MULT: 64-bit product; DIV: HI=remainder, LO=quotient.
REQ-009 The block SHALL provide `ready_o  out  1`: result_o valid.
REQ-010 The block SHALL provide `stallreq_o  out  1`: pipeline stall request to the stall controller.
REQ-011 The block SHALL provide `busy_o  out  1`: the state machine is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, DIVZERO, CALC, DONE, with a registered state and a 6-bit iteration counter cnt.
REQ-013 IDLE with start_i=1 and annul_i=0 SHALL latch op_i, opa_i and opb_i.
- Next state for DIV/DIVU with opb_i=0: DIVZERO.
- Next state otherwise: CALC, with cnt=0.
REQ-014 Latched operands SHALL be used for the whole operation; changes on op_i, opa_i and opb_i after acceptance are ignored.
REQ-015 For MULT and DIV, operands SHALL be converted to magnitudes at latch time, and the operand sign bits SHALL be retained.
REQ-016 CALC SHALL perform one iteration per cycle for exactly 32 cycles (cnt 0..31), then go to DONE.
- Multiply: shift-add (one partial product per iteration).
- Divide: restoring, one quotient bit per iteration (65-bit partial remainder/quotient register).
REQ-017 Sign fix on entry to DONE (MULT/DIV only):
- Product is negated if the operand signs differ.
- Quotient is negated if the signs differ.
- Remainder takes the sign of the dividend.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0; no trap.
REQ-019 DIVZERO SHALL go to DONE after one cycle with result {HI,LO}=64'h0.
REQ-020 In DONE, ready_o=1 and result_o SHALL hold the result, stable.
- DONE SHALL stay while start_i=1.
- DONE SHALL return to IDLE the cycle after start_i=0.
REQ-021 result_o SHALL be 64'h0 and ready_o=0 in every state other than DONE.
REQ-022 stallreq_o SHALL be combinational:
- 1 when (state==IDLE and start_i=1 and annul_i=0), or state==CALC, or state==DIVZERO.
- 0 otherwise, including DONE.
REQ-023 annul_i=1 in any state SHALL force IDLE at the next edge, with no ready_o pulse and internal results discarded; annul_i overrides start_i in the same cycle.
REQ-024 Latency from the accepting edge to ready_o=1 SHALL be exactly 33 cycles for mult and nonzero divide, and 2 cycles for divide by zero.
REQ-025 A new operation SHALL be accepted only from IDLE; back-to-back operations need start_i to deassert for at least one cycle.
REQ-026 busy_o SHALL be 1 in DIVZERO, CALC and DONE, and 0 in IDLE.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE and set cnt=0, latched operands=0 and the result register=0, overriding start_i and annul_i.
REQ-028 While in reset and on the cycle after it, outputs SHALL read ready_o=0, stallreq_o=0 (start_i=0), busy_o=0 and result_o=64'h0.
REQ-029 Reset asserted in CALC or DONE SHALL abandon the operation with no ready_o pulse.

Verification
REQ-030 DIVU 100/7:
- Stimulus: start_i=1, op=11.
- Response: stallreq_o=1 for 33 cycles; ready_o=1 at edge+33; result_o=0x00000002_0000000E.
REQ-031 DIV signed:
- Stimulus: opa=0xFFFFFFF9 (-7), opb=2.
- Response: result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3).
REQ-032 MULT:
- Stimulus: opa=0xFFFFFFFD (-3), opb=5.
- Response: result_o=0xFFFFFFFF_FFFFFFF1.
REQ-033 MULTU:
- Stimulus: 0xFFFFFFFF*0xFFFFFFFF.
- Response: result_o=0xFFFFFFFE_00000001.
REQ-034 DIV by zero:
- Stimulus: opa=5, opb=0.
- Response: ready_o=1 two cycles after acceptance; result_o=64'h0.
REQ-035 Annul and reset mid-operation:
- Stimulus: annul_i pulsed at CALC cycle 10.
- Response: busy_o=0 next cycle; no ready_o; a subsequent DIVU 9/3 gives 0x00000000_00000003.
- Stimulus: rst at CALC cycle 20.
- Response: IDLE, all outputs zero.
